// File: rtl/prbs31_checker_if.sv
// Serial PRBS31 checker bus: received bit stream in, lock/error status out.
interface prbs31_checker_if #(
  parameter int ERR_WIDTH = 16
);
  logic                 din;
  logic                 din_valid;
  logic                 clr;
  logic                 locked;
  logic                 err;
  logic [ERR_WIDTH-1:0] err_count;
  logic [31:0]          bit_count;

  // Stimulus side drives the bit stream and clear.
  modport master (
    output din, din_valid, clr,
    input  locked, err, err_count, bit_count
  );

  // Checker side consumes the stream and reports status.
  modport slave (
    input  din, din_valid, clr,
    output locked, err, err_count, bit_count
  );
endinterface

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial checker.
// Seeds its history from the incoming stream, qualifies lock by a run of
// correct predictions, then free-runs the predictor so each corrupted bit is
// counted once. Too many errors in a 64-bit window drops lock and reseeds.
module prbs31_checker #(
  parameter int LOCK_COUNT  = 32,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_WIDTH   = 16
) (
  input logic              clk,
  input logic              rst_n,
  prbs31_checker_if.slave  bus
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(LOSS_THRESH + 1);
  localparam logic [MW-1:0]        LOCK_V = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]        ONE_M  = MW'(1);
  localparam logic [WW-1:0]        LOSS_V = WW'(LOSS_THRESH);
  localparam logic [ERR_WIDTH-1:0] ONE_E  = ERR_WIDTH'(1);

  typedef enum logic [1:0] {SEED, LOCKING, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [30:0]          hist_q, hist_d;
  logic [4:0]           seed_q, seed_d;
  logic [MW-1:0]        match_q, match_d;
  logic [5:0]           win_q, win_d;
  logic [WW-1:0]        werr_q, werr_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [ERR_WIDTH-1:0] ecnt_q, ecnt_d;
  logic [31:0]          bcnt_q, bcnt_d;

  logic        pred;
  logic        miss;
  logic [30:0] hist_din;
  logic [WW-1:0] werr_inc;

  // hist[0] is the newest bit; the recurrence taps are n-28 and n-31.
  assign pred     = hist_q[27] ^ hist_q[30];
  assign miss     = bus.din ^ pred;
  assign hist_din = {hist_q[29:0], bus.din};
  assign werr_inc = werr_q + WW'(miss);

  // Next-state: seeding, lock qualification, locked checking, counter clear.
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    seed_d   = seed_q;
    match_d  = match_q;
    win_d    = win_q;
    werr_d   = werr_q;
    ecnt_d   = ecnt_q;
    bcnt_d   = bcnt_q;
    err_d    = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        SEED: begin
          hist_d = hist_din;
          seed_d = seed_q + 5'd1;
          if (seed_q == 5'd30) begin
            state_d = LOCKING;
            seed_d  = '0;
            match_d = '0;
          end
        end
        LOCKING: begin
          hist_d = hist_din;
          // An all-zero history predicts zeros forever; never let it lock.
          if (miss || hist_din == '0) begin
            match_d = '0;
          end else if (match_q == LOCK_V - ONE_M) begin
            state_d = LOCKED;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + ONE_M;
          end
        end
        LOCKED: begin
          // Shift the prediction, not din, so one bad bit is not re-seen
          // later through the taps.
          hist_d = {hist_q[29:0], pred};
          err_d  = miss;
          if (bcnt_q != '1) bcnt_d = bcnt_q + 32'd1;
          if (miss && ecnt_q != '1) ecnt_d = ecnt_q + ONE_E;
          win_d = win_q + 6'd1;
          if (werr_inc >= LOSS_V) begin
            state_d = SEED;
            seed_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == 6'd63) begin
            werr_d = '0;
          end else begin
            werr_d = werr_inc;
          end
        end
        default: ;
      endcase
    end
    // Clear overrides any same-cycle increment; err pulse is unaffected.
    if (bus.clr) begin
      ecnt_d = '0;
      bcnt_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEED;
      hist_q   <= '0;
      seed_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      seed_q   <= seed_d;
      match_q  <= match_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = ecnt_q;
  assign bus.bit_count = bcnt_q;
endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: stimulus queues expected err pulses
// and lock transitions; a negedge monitor pops and compares them.
module tb_prbs31_checker;
  localparam int EW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  prbs31_checker_if #(.ERR_WIDTH(EW)) bus();

  prbs31_checker #(.LOCK_COUNT(32), .LOSS_THRESH(8), .ERR_WIDTH(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
  } err_ev_t;

  err_ev_t     err_exp[$];
  int          lock_exp[$];
  int          unlock_exp[$];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic [30:0] g      = 31'd1;
  logic        prev_locked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
  endtask

  // Reference PRBS31 generator seeded with 1; emits the newly computed bit.
  task automatic gen_bit(output logic b);
    b = g[27] ^ g[30];
    g = {g[29:0], b};
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic step(input logic d, input logic v, input logic c);
    bus.din       = d;
    bus.din_valid = v;
    bus.clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_err(input int cnt);
    err_ev_t e;
    e.cyc = cyc;
    e.cnt = cnt;
    err_exp.push_back(e);
  endtask

  // Monitor: every err pulse and lock edge must match a queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_locked = 1'b0;
    end else begin
      if (bus.err) begin
        if (err_exp.size() == 0) unexpected("err_pulse");
        else begin
          err_ev_t e;
          e = err_exp.pop_front();
          chk("err_cycle", cyc, e.cyc);
          chk("err_count_at_pulse", bus.err_count, e.cnt);
        end
      end
      if (bus.locked && !prev_locked) begin
        if (lock_exp.size() == 0) unexpected("lock_rise");
        else chk("lock_cycle", cyc, lock_exp.pop_front());
      end
      if (!bus.locked && prev_locked) begin
        if (unlock_exp.size() == 0) unexpected("lock_fall");
        else chk("unlock_cycle", cyc, unlock_exp.pop_front());
      end
      prev_locked = bus.locked;
    end
  end

  initial begin
    logic b;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr = 1'b0;

    // Reset state while held in reset.
    #3;
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_bit_count", bus.bit_count, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Stuck-at-zero stream must never lock.
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0);
    chk("zero_locked", bus.locked, 0);
    chk("zero_err_count", bus.err_count, 0);
    chk("zero_bit_count", bus.bit_count, 0);

    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Clean stream: lock right after the 63rd valid bit.
    for (int i = 1; i <= 100; i++) begin
      gen_bit(b); step(b, 1'b1, 1'b0);
      if (i == 63) lock_exp.push_back(cyc);
    end
    chk("clean_locked", bus.locked, 1);
    chk("clean_bit_count", bus.bit_count, 37);
    chk("clean_err_count", bus.err_count, 0);

    // Single inverted bit then 100 clean bits.
    gen_bit(b); step(~b, 1'b1, 1'b0); exp_err(1);
    for (int i = 0; i < 100; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); end
    chk("single_err_count", bus.err_count, 1);
    chk("single_locked", bus.locked, 1);
    chk("single_bit_count", bus.bit_count, 138);

    // Clear with no valid bit.
    step(1'b0, 1'b0, 1'b1);
    chk("clr_err_count", bus.err_count, 0);
    chk("clr_bit_count", bus.bit_count, 0);

    // Eight errors within one window: lock drops on the eighth.
    for (int i = 0; i < 15; i++) begin
      gen_bit(b);
      if (i % 2 == 0) begin
        step(~b, 1'b1, 1'b0); exp_err(i / 2 + 1);
        if (i == 14) unlock_exp.push_back(cyc);
      end else step(b, 1'b1, 1'b0);
    end
    chk("loss_locked", bus.locked, 0);
    chk("loss_err_count", bus.err_count, 8);
    chk("loss_bit_count", bus.bit_count, 15);

    // Relock after 63 further clean bits.
    for (int i = 1; i <= 63; i++) begin
      gen_bit(b); step(b, 1'b1, 1'b0);
      if (i == 63) lock_exp.push_back(cyc);
    end
    chk("relock_bit_count", bus.bit_count, 15);

    // din_valid toggling: 20 valid bits among 40 cycles.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin gen_bit(b); step(b, 1'b1, 1'b0); end
      else step(1'b0, 1'b0, 1'b0);
    end
    chk("toggle_bit_count", bus.bit_count, 35);
    chk("toggle_locked", bus.locked, 1);

    // Clear coincident with an injected error: pulse yes, count cleared.
    gen_bit(b); step(~b, 1'b1, 1'b1); exp_err(0);
    chk("clr_err_err_count", bus.err_count, 0);
    chk("clr_err_bit_count", bus.bit_count, 0);
    for (int i = 0; i < 3; i++) begin gen_bit(b); step(b, 1'b1, 1'b0); end

    // Asynchronous reset between edges while locked.
    bus.din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", bus.locked, 0);
    chk("arst_err", bus.err, 0);
    chk("arst_err_count", bus.err_count, 0);
    chk("arst_bit_count", bus.bit_count, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 63; i++) begin
      gen_bit(b); step(b, 1'b1, 1'b0);
      if (i == 63) lock_exp.push_back(cyc);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("final_locked", bus.locked, 1);
    chk("pending_err_events", err_exp.size(), 0);
    chk("pending_lock_events", lock_exp.size(), 0);
    chk("pending_unlock_events", unlock_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
